// File: rtl/render_cmd_sender_pkg.sv
// rtl/render_cmd_sender_pkg.sv - shared type codes, frame lengths and state encoding for the render byte stream
package render_cmd_sender_pkg;

   // Object type codes carried in byte 0 of every frame
   localparam logic [7:0] OBJ_POINT = 8'd0;
   localparam logic [7:0] OBJ_LINE  = 8'd1;
   localparam logic [7:0] OBJ_TRI   = 8'd2;

   // Frame lengths in bytes (type byte plus coordinates)
   localparam logic [2:0] LEN_POINT = 3'd3;
   localparam logic [2:0] LEN_LINE  = 3'd5;
   localparam logic [2:0] LEN_TRI   = 3'd7;

   localparam int unsigned DEF_ACK_TIMEOUT = 255;

   // Sender state encoding
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_RU  = 2'd1;
   localparam logic [1:0] ST_SEND     = 2'd2;
   localparam logic [1:0] ST_WAIT_ACK = 2'd3;

   typedef struct packed {
      logic [7:0] typ;
      logic [7:0] x0;
      logic [7:0] y0;
      logic [7:0] x1;
      logic [7:0] y1;
      logic [7:0] x2;
      logic [7:0] y2;
   } obj_desc_t;

   // Frame length for a legal type; illegal types never reach this
   function automatic logic [2:0] frame_len(input logic [7:0] typ);
      case (typ)
         OBJ_POINT: frame_len = LEN_POINT;
         OBJ_LINE:  frame_len = LEN_LINE;
         default:   frame_len = LEN_TRI;
      endcase
   endfunction

endpackage

// File: rtl/render_cmd_sender_frame_byte_mux.sv
// rtl/render_cmd_sender_frame_byte_mux.sv - selects the frame byte for a given byte index
module frame_byte_mux
   import render_cmd_sender_pkg::*;
(
   input  logic [2:0] idx_i,
   input  obj_desc_t  desc_i,
   output logic [7:0] byte_o
);

   // Byte order on the wire: type, X0, Y0, X1, Y1, X2, Y2
   always_comb begin
      byte_o = 8'h00;
      case (idx_i)
         3'd0:    byte_o = desc_i.typ;
         3'd1:    byte_o = desc_i.x0;
         3'd2:    byte_o = desc_i.y0;
         3'd3:    byte_o = desc_i.x1;
         3'd4:    byte_o = desc_i.y1;
         3'd5:    byte_o = desc_i.x2;
         3'd6:    byte_o = desc_i.y2;
         default: byte_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/render_cmd_sender.sv
// rtl/render_cmd_sender.sv - serialises object descriptors into render unit byte frames
module render_cmd_sender
   import render_cmd_sender_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [7:0] CMD_TYPE,
   input  logic [7:0] CMD_X0,
   input  logic [7:0] CMD_Y0,
   input  logic [7:0] CMD_X1,
   input  logic [7:0] CMD_Y1,
   input  logic [7:0] CMD_X2,
   input  logic [7:0] CMD_Y2,
   input  logic       STATUS,
   input  logic       FinishRead,
   output logic       READING,
   output logic [7:0] RByte,
   output logic       DONE,
   output logic       ERR
);

   localparam logic [7:0] ACK_LIMIT = ACK_TIMEOUT[7:0];

   logic [1:0] state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic       reading_q, reading_d;
   logic [7:0] rbyte_q, rbyte_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       cap_en;
   obj_desc_t  desc_q;
   logic [7:0] mux_byte;

   assign CMD_READY = (state_q == ST_IDLE);
   assign READING   = reading_q;
   assign RByte     = rbyte_q;
   assign DONE      = done_q;
   assign ERR       = err_q;

   frame_byte_mux u_mux (
      .idx_i  (idx_q),
      .desc_i (desc_q),
      .byte_o (mux_byte)
   );

   // Next-state decode for the frame sequencer and its registered outputs
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      reading_d = reading_q;
      rbyte_d   = rbyte_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cap_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               cap_en = 1'b1;
               if (CMD_TYPE > OBJ_TRI) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_RU;
                  len_d   = frame_len(CMD_TYPE);
                  idx_d   = 3'd0;
               end
            end
         end
         ST_WAIT_RU: begin
            if (!STATUS) begin
               state_d   = ST_SEND;
               reading_d = 1'b1;
               rbyte_d   = mux_byte;
               idx_d     = idx_q + 3'd1;
            end
         end
         ST_SEND: begin
            // idx_q names the next byte; reaching len_q means the last one is already on the bus
            if (idx_q == len_q) begin
               state_d   = ST_WAIT_ACK;
               reading_d = 1'b0;
               rbyte_d   = 8'h00;
               cnt_d     = 8'd0;
            end else begin
               rbyte_d = mux_byte;
               idx_d   = idx_q + 3'd1;
            end
         end
         default: begin
            // An acknowledge on the same edge as the timeout still wins
            if (FinishRead) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == ACK_LIMIT) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
      endcase
   end

   // Sequencer and output registers with synchronous active-low reset
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q   <= ST_IDLE;
         idx_q     <= 3'd0;
         len_q     <= 3'd0;
         cnt_q     <= 8'd0;
         reading_q <= 1'b0;
         rbyte_q   <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         reading_q <= reading_d;
         rbyte_q   <= rbyte_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Descriptor holding registers, loaded only on the accept handshake
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         desc_q <= '0;
      end else if (cap_en) begin
         desc_q <= '{typ: CMD_TYPE, x0: CMD_X0, y0: CMD_Y0, x1: CMD_X1,
                     y1: CMD_Y1, x2: CMD_X2, y2: CMD_Y2};
      end
   end

endmodule

// File: tb/tb_render_cmd_sender.sv
// tb/tb_render_cmd_sender.sv - self-checking bench for render_cmd_sender
module tb_render_cmd_sender;

   logic       ACLK = 1'b0;
   logic       ARESETn;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [7:0] CMD_TYPE, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1, CMD_X2, CMD_Y2;
   logic       STATUS;
   logic       FinishRead;
   logic       READING;
   logic [7:0] RByte;
   logic       DONE;
   logic       ERR;

   int checks = 0;
   int errors = 0;

   always #5 ACLK = ~ACLK;

   render_cmd_sender #(.ACK_TIMEOUT(4)) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .CMD_VALID  (CMD_VALID),
      .CMD_READY  (CMD_READY),
      .CMD_TYPE   (CMD_TYPE),
      .CMD_X0     (CMD_X0),
      .CMD_Y0     (CMD_Y0),
      .CMD_X1     (CMD_X1),
      .CMD_Y1     (CMD_Y1),
      .CMD_X2     (CMD_X2),
      .CMD_Y2     (CMD_Y2),
      .STATUS     (STATUS),
      .FinishRead (FinishRead),
      .READING    (READING),
      .RByte      (RByte),
      .DONE       (DONE),
      .ERR        (ERR)
   );

   typedef struct {
      logic [7:0] typ;
      logic [7:0] v [6];
      int         busy;      // edges with STATUS=1 after accept
      int         ack_dly;   // WAIT_ACK edges before FinishRead; -1 = never
      bit         stray;     // stray FinishRead and STATUS during SEND
      int         exp_len;   // expected bytes on the wire; 0 = illegal
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] exp_bytes [7];
      exp_bytes[0] = v.typ;
      for (int i = 0; i < 6; i++) exp_bytes[i+1] = v.v[i];
      CMD_TYPE = v.typ;
      CMD_X0 = v.v[0]; CMD_Y0 = v.v[1]; CMD_X1 = v.v[2];
      CMD_Y1 = v.v[3]; CMD_X2 = v.v[4]; CMD_Y2 = v.v[5];
      STATUS = (v.busy > 0);
      chk("ready_before_accept", CMD_READY, 1);
      CMD_VALID = 1'b1;
      step();
      CMD_VALID = 1'b0;
      CMD_TYPE = 8'hEE; CMD_X0 = 8'hEE; CMD_Y2 = 8'hEE;
      if (v.exp_len == 0) begin
         chk("illegal_err", ERR, 1);
         chk("illegal_reading", READING, 0);
         chk("illegal_ready", CMD_READY, 1);
         step();
         chk("illegal_err_clear", ERR, 0);
         return;
      end
      chk("wait_ru_ready", CMD_READY, 0);
      chk("wait_ru_reading", READING, 0);
      for (int b = 0; b < v.busy; b++) begin
         step();
         chk("busy_no_reading", READING, 0);
      end
      STATUS = 1'b0;
      step();
      for (int i = 0; i < v.exp_len; i++) begin
         chk("byte_strobe", READING, 1);
         chk($sformatf("byte_%0d", i), RByte, exp_bytes[i]);
         FinishRead = v.stray && (i == 1);
         STATUS     = v.stray && (i >= 1);
         step();
      end
      FinishRead = 1'b0;
      STATUS = 1'b0;
      chk("frame_end_reading", READING, 0);
      chk("frame_end_rbyte", RByte, 0);
      chk("frame_end_ready", CMD_READY, 0);
      chk("frame_end_done", DONE, 0);
      if (v.ack_dly < 0) begin
         for (int j = 0; j < 4; j++) begin
            step();
            if (j < 3) chk("timeout_wait_err", ERR, 0);
            chk("timeout_no_done", DONE, 0);
         end
         chk("timeout_err", ERR, 1);
         chk("timeout_ready", CMD_READY, 1);
         step();
         chk("timeout_err_clear", ERR, 0);
         return;
      end
      for (int j = 0; j < v.ack_dly; j++) begin
         step();
         chk("ack_wait_done", DONE, 0);
         chk("ack_wait_err", ERR, 0);
      end
      FinishRead = 1'b1;
      step();
      FinishRead = 1'b0;
      chk("done_pulse", DONE, 1);
      chk("done_ready", CMD_READY, 1);
      chk("done_no_err", ERR, 0);
      step();
      chk("done_clear", DONE, 0);
   endtask

   initial begin
      vecs[0] = '{typ: 8'd1, v: '{8'd10, 8'd20, 8'd30, 8'd40, 8'hC1, 8'hC2}, busy: 0, ack_dly: 2, stray: 0, exp_len: 5};
      vecs[1] = '{typ: 8'd2, v: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, busy: 6, ack_dly: 0, stray: 0, exp_len: 7};
      vecs[2] = '{typ: 8'd7, v: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, busy: 0, ack_dly: 0, stray: 0, exp_len: 0};
      vecs[3] = '{typ: 8'd0, v: '{8'hAA, 8'h55, 8'h99, 8'h98, 8'h97, 8'h96}, busy: 0, ack_dly: -1, stray: 0, exp_len: 3};
      vecs[4] = '{typ: 8'd0, v: '{8'h03, 8'h04, 8'h77, 8'h78, 8'h79, 8'h7A}, busy: 1, ack_dly: 0, stray: 0, exp_len: 3};
      vecs[5] = '{typ: 8'd1, v: '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h5A, 8'hA5}, busy: 0, ack_dly: 1, stray: 1, exp_len: 5};
      vecs[6] = '{typ: 8'd3, v: '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}, busy: 2, ack_dly: 0, stray: 0, exp_len: 0};
      vecs[7] = '{typ: 8'd2, v: '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20}, busy: 0, ack_dly: 3, stray: 1, exp_len: 7};

      ARESETn = 1'b0; CMD_VALID = 1'b0; STATUS = 1'b0; FinishRead = 1'b0;
      CMD_TYPE = 0; CMD_X0 = 0; CMD_Y0 = 0; CMD_X1 = 0; CMD_Y1 = 0; CMD_X2 = 0; CMD_Y2 = 0;
      step();
      step();
      chk("rst_ready", CMD_READY, 1);
      chk("rst_reading", READING, 0);
      chk("rst_rbyte", RByte, 0);
      chk("rst_done", DONE, 0);
      chk("rst_err", ERR, 0);
      ARESETn = 1'b1;
      step();

      // Stray acknowledge while idle
      FinishRead = 1'b1;
      step();
      FinishRead = 1'b0;
      chk("idle_stray_done", DONE, 0);
      chk("idle_stray_ready", CMD_READY, 1);
      step();
      chk("idle_stray_done2", DONE, 0);

      for (int n = 0; n < 8; n++) run_vec(vecs[n]);

      // Reset during the third byte of a triangle
      CMD_TYPE = 8'd2; CMD_X0 = 8'h21; CMD_Y0 = 8'h22; CMD_X1 = 8'h23;
      CMD_Y1 = 8'h24; CMD_X2 = 8'h25; CMD_Y2 = 8'h26;
      CMD_VALID = 1'b1;
      step();
      CMD_VALID = 1'b0;
      step();
      chk("mid_byte0", RByte, 8'd2);
      step();
      step();
      chk("mid_byte2_reading", READING, 1);
      chk("mid_byte2", RByte, 8'h22);
      ARESETn = 1'b0;
      step();
      ARESETn = 1'b1;
      chk("mid_rst_reading", READING, 0);
      chk("mid_rst_rbyte", RByte, 0);
      chk("mid_rst_ready", CMD_READY, 1);
      FinishRead = 1'b1;
      step();
      FinishRead = 1'b0;
      chk("mid_rst_stray_done", DONE, 0);
      chk("mid_rst_stray_ready", CMD_READY, 1);
      chk("mid_rst_stray_reading", READING, 0);
      step();
      chk("mid_rst_done2", DONE, 0);

      // Normal frame after the abandoned one
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
